// File: rtl/pa_isa_pkg.sv
// Shared ISA definitions for the decode stage: opcode constants, fetch PC
// select encodings and the decode controller state enum.
package pa_isa_pkg;

  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_BZ   = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    SEL_BOOT   = 2'b00,
    SEL_INC    = 2'b01,
    SEL_BRANCH = 2'b10,
    SEL_ZERO   = 2'b11
  } sel_pc_e;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALTED
  } state_e;

endpackage

// File: rtl/decode_branch_unit.sv
// Combinational branch resolution: PC-relative target and taken decision.
// BZ redirects only when built with DECODE_BZ_EN.
module decode_branch_unit
  import pa_isa_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [15:0] dec_pc,
  input  logic        zero_flag,
  output logic        taken,
  output logic [15:0] target
);

  logic [3:0] op;
  logic [7:0] imm8;
  logic       unused_bits;

  assign op   = ir[15:12];
  assign imm8 = ir[7:0];

  // Halfword offset: sign-extended imm8 shifted left by one, wraps at 2^16.
  assign target = dec_pc + {{7{imm8[7]}}, imm8, 1'b0};

`ifdef DECODE_BZ_EN
  assign unused_bits = ^ir[11:8];
  assign taken = (op == OP_BR) || ((op == OP_BZ) && zero_flag);
`else
  assign unused_bits = ^{ir[11:8], zero_flag};
  assign taken = (op == OP_BR);
`endif

endmodule

// File: rtl/decode_ctrl.sv
// Decode controller: BOOT/RUN/HALTED FSM, instruction register, fetch PC shadow.
// Optional macro DECODE_BZ_EN enables the BZ conditional branch.
module decode_ctrl
  import pa_isa_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  inst_code_high,
  input  logic [7:0]  inst_code_low,
  input  logic [15:0] initial_inst_addr,
  input  logic        stall,
  input  logic        zero_flag,
  output logic [1:0]  sel_pc,
  output logic [15:0] branch_pc,
  output logic        enable_pc,
  output logic        dec_valid,
  output logic [15:0] dec_pc,
  output logic [3:0]  opcode,
  output logic [3:0]  rd,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [7:0]  imm8,
  output logic        halted
);

  state_e      state, state_nxt;
  sel_pc_e     sel;
  logic [15:0] ir;
  logic [15:0] fetch_pc;
  logic [15:0] next_pc;
  logic        ir_valid;
  logic        taken;
  logic        redirect;

  decode_branch_unit u_branch (
    .ir        (ir),
    .dec_pc    (dec_pc),
    .zero_flag (zero_flag),
    .taken     (taken),
    .target    (branch_pc)
  );

  assign opcode    = ir[15:12];
  assign rd        = ir[11:8];
  assign ra        = ir[7:4];
  assign rb        = ir[3:0];
  assign imm8      = ir[7:0];
  assign dec_valid = ir_valid && (state == ST_RUN);
  assign halted    = (state == ST_HALTED);
  assign sel_pc    = sel;

  always_comb begin
    state_nxt = state;
    sel       = SEL_INC;
    enable_pc = 1'b0;
    redirect  = 1'b0;
    unique case (state)
      ST_BOOT: begin
        sel       = SEL_BOOT;
        // Held low while reset is asserted so fetch sees no enable.
        enable_pc = reset;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          if (ir_valid && (ir[15:12] == OP_HALT)) begin
            state_nxt = ST_HALTED;
          end else begin
            enable_pc = 1'b1;
            if (ir_valid && taken) begin
              redirect = 1'b1;
              sel      = SEL_BRANCH;
            end
          end
        end
      end
      ST_HALTED: begin
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  always_comb begin
    next_pc = fetch_pc + 16'd2;
    unique case (sel)
      SEL_BOOT:   next_pc = initial_inst_addr;
      SEL_INC:    next_pc = fetch_pc + 16'd2;
      SEL_BRANCH: next_pc = branch_pc;
      SEL_ZERO:   next_pc = '0;
      default:    next_pc = fetch_pc + 16'd2;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_BOOT;
      ir       <= '0;
      ir_valid <= 1'b0;
      dec_pc   <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (enable_pc) fetch_pc <= next_pc;
      // On redirect the fetched word is the wrong path; load it but mark it invalid.
      if ((state == ST_RUN) && enable_pc) begin
        ir       <= {inst_code_high, inst_code_low};
        ir_valid <= ~redirect;
        dec_pc   <= fetch_pc;
      end
    end
  end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: value assumed in the fetch PC shadow at reset.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have ports inst_code_high / inst_code_low  in  8 / 8: instruction bytes presented by fetch for the current PC, same cycle.
REQ-005 SHALL have port initial_inst_addr  in  16: boot address.
REQ-006 SHALL have ports stall  in  1 (downstream not ready) and zero_flag  in  1 (condition for BZ).
REQ-007 SHALL have ports sel_pc  out  2, branch_pc  out  16, enable_pc  out  1: PC control to fetch. sel_pc encoding: 00 boot, 01 PC+2, 10 branch, 11 zero.
REQ-008 SHALL have ports dec_valid  out  1, dec_pc  out  16, opcode  out  4, rd  out  4, ra  out  4, rb  out  4, imm8  out  8, halted  out  1.

Function
REQ-009 SHALL implement a 3-state FSM: BOOT, RUN, HALTED.
REQ-010 BOOT SHALL last exactly one cycle after reset deassertion, drive sel_pc=00 and enable_pc=1, keep ir_valid=0, load fetch_pc shadow <= initial_inst_addr, then go to RUN.
REQ-011 The instruction register (IR, 16 bit = {high,low}) plus ir_valid and dec_pc SHALL capture fetch output on every edge where the FSM is in RUN and enable_pc=1; dec_pc <= fetch_pc shadow; fetch_pc shadow <= PC value selected by sel_pc.
REQ-012 Field outputs SHALL be combinational from IR: opcode=IR[15:12], rd=IR[11:8], ra=IR[7:4], rb=IR[3:0], imm8=IR[7:0]; dec_valid=ir_valid and state==RUN.
REQ-013 In RUN with stall=1: enable_pc=0, sel_pc=01, IR, ir_valid, dec_pc and shadow held; no branch or halt resolved.
REQ-014 In RUN with stall=0 and no redirect: enable_pc=1, sel_pc=01.
REQ-015 Redirect SHALL occur when ir_valid=1, stall=0 and opcode=4'hC (BR), or opcode=4'hD (BZ) with zero_flag=1.
REQ-016 On redirect: sel_pc=10, branch_pc=dec_pc + {{7{imm8[7]}},imm8,1'b0} modulo 2^16, enable_pc=1; at that edge ir_valid <= 0 (wrong-path instruction discarded); penalty exactly one bubble cycle.
REQ-017 branch_pc SHALL equal the computed target in every cycle (don't-care for fetch unless sel_pc=10).
REQ-018 opcode=4'hF with ir_valid=1 and stall=0 SHALL move to HALTED at that edge; enable_pc=0 in that cycle; IR not reloaded.
REQ-019 HALTED: enable_pc=0, sel_pc=01, dec_valid=0, halted=1; exit only via reset.
REQ-020 Opcodes 0x0-0xB and 0xE SHALL pass through with no PC effect.

Reset
REQ-021 While reset=0: state=BOOT, IR=16'h0000, ir_valid=0, dec_pc=RESET_PC, fetch_pc shadow=RESET_PC; outputs sel_pc=00, enable_pc=0, dec_valid=0, halted=0, branch_pc=RESET_PC.
REQ-022 Reset asserted mid-branch or mid-stall SHALL abort immediately; no redirect after release except via new instructions.

Configuration
REQ-023 Macro DECODE_BZ_EN: defined -> BZ behaves per REQ-015/016; undefined -> opcode 0xD is passed through as a non-redirecting instruction and zero_flag is ignored (port retained).

Structure
REQ-024 Shared package pa_isa_pkg SHALL hold opcode constants (OP_BR=4'hC, OP_BZ=4'hD, OP_HALT=4'hF), sel_pc encodings, and the FSM state enum.
REQ-025 Target arithmetic and redirect decision SHALL live in one combinational sub-module decode_branch_unit (inputs IR, dec_pc, zero_flag; outputs taken, target).

Verification
REQ-026 Reset release, initial_inst_addr=16'h0100 -> one cycle sel_pc=00; next cycle sel_pc=01; first dec_valid with dec_pc=16'h0100.
REQ-027 IR=16'hC0FE at dec_pc=16'h0104 -> sel_pc=10, branch_pc=16'h0100; next cycle dec_valid=0; following cycle dec_pc=16'h0100.
REQ-028 IR=16'hD005, zero_flag=1 then 0 -> with DECODE_BZ_EN: branch_pc=dec_pc+10, redirect only when 1; without: never redirect.
REQ-029 stall=1 for 3 cycles holding IR=16'hC010 -> enable_pc=0, no redirect; redirect in first cycle after stall=0.
REQ-030 IR=16'hF000 -> halted=1 next cycle, enable_pc=0 thereafter; mid-halt reset -> BOOT restarts at initial_inst_addr.
REQ-031 Branch at dec_pc=16'hFFFE with imm8=8'h02 -> branch_pc=16'h0002 (wrap).
